// File: rtl/i2c_eeprom_slave.sv
// I2C EEPROM-style target: byte memory with byte/page write, current and random read, sequential auto-increment.
// Latency: SDA responses land 3 sys_clk after the SCL pin edge (2-FF sync + registered drive); wr_pulse 1 cycle after the 8th rise.
// Backpressure: none; the bus master paces everything through SCL, and the target only ever pulls SDA low.
module i2c_eeprom_slave #(
  parameter logic [6:0] DEVICE_ADDR = 7'b1010011,
  parameter int         ADDR_NUM    = 1,
  parameter int         MEM_AW      = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              i2c_scl,
  inout  wire               i2c_sda,
  output logic              busy,
  output logic              wr_pulse,
  output logic [MEM_AW-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_ACK_DEV, S_ADDR_H, S_ACK_AH, S_ADDR_L, S_ACK_AL,
    S_WR_DATA, S_ACK_WR, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  logic r_scl_s1, r_scl_s2, r_scl_d;
  logic r_sda_s1, r_sda_s2, r_sda_d;

  state_t            r_state;
  logic [2:0]        r_cnt;
  logic              r_done;     // 8 bits of the current byte seen; waiting for the fall that opens the 9th clock
  logic [7:0]        r_shift;
  logic              r_rw;
  logic [7:0]        r_addr_hi;
  logic [MEM_AW-1:0] r_ptr;
  logic              r_sda_oe;
  logic              r_busy;
  logic              r_wr_pulse;
  logic [MEM_AW-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic [7:0]        r_mem [0:(1<<MEM_AW)-1];

  state_t            w_state_nxt;
  logic [2:0]        w_cnt_nxt;
  logic              w_done_nxt;
  logic [7:0]        w_shift_nxt;
  logic              w_rw_nxt;
  logic [7:0]        w_addr_hi_nxt;
  logic [MEM_AW-1:0] w_ptr_nxt;
  logic              w_sda_oe_nxt;
  logic              w_busy_nxt;
  logic              w_wr_en;

  logic              w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]        w_byte;
  logic [MEM_AW-1:0] w_ptr_inc;

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  // START/STOP need SCL high both before and after the SDA edge
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_byte     = {r_shift[6:0], r_sda_s2};
  assign w_ptr_inc  = r_ptr + MEM_AW'(1);

  assign i2c_sda  = r_sda_oe ? 1'b0 : 1'bz;
  assign busy     = r_busy;
  assign wr_pulse = r_wr_pulse;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;

  // Synchronise SCL/SDA and keep one cycle of history for edge detection
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_d <= 1'b1;
      r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_d <= 1'b1;
    end else begin
      r_scl_s1 <= i2c_scl;  r_scl_s2 <= r_scl_s1; r_scl_d <= r_scl_s2;
      r_sda_s1 <= i2c_sda;  r_sda_s2 <= r_sda_s1; r_sda_d <= r_sda_s2;
    end
  end

  // Protocol state and datapath registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_done     <= 1'b0;
      r_shift    <= 8'h00;
      r_rw       <= 1'b0;
      r_addr_hi  <= 8'h00;
      r_ptr      <= '0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_done     <= w_done_nxt;
      r_shift    <= w_shift_nxt;
      r_rw       <= w_rw_nxt;
      r_addr_hi  <= w_addr_hi_nxt;
      r_ptr      <= w_ptr_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_busy     <= w_busy_nxt;
      r_wr_pulse <= w_wr_en;
      if (w_wr_en) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= w_byte;
      end
    end
  end

  // Byte memory; contents survive reset
  always_ff @(posedge sys_clk) begin
    if (w_wr_en) r_mem[r_ptr] <= w_byte;
  end

  // Next-state: bus conditions first, then per-state SCL edge handling
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_done_nxt    = r_done;
    w_shift_nxt   = r_shift;
    w_rw_nxt      = r_rw;
    w_addr_hi_nxt = r_addr_hi;
    w_ptr_nxt     = r_ptr;
    w_sda_oe_nxt  = r_sda_oe;
    w_busy_nxt    = r_busy;
    w_wr_en       = 1'b0;

    if (w_stop) begin
      w_state_nxt  = S_IDLE;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
      w_done_nxt   = 1'b0;
    end else if (w_start) begin
      w_state_nxt  = S_DEV_ADDR;
      w_cnt_nxt    = 3'd0;
      w_done_nxt   = 1'b0;
      w_sda_oe_nxt = 1'b0;
    end else begin
      case (r_state)
        S_DEV_ADDR, S_ADDR_H, S_ADDR_L, S_WR_DATA: begin
          if (w_scl_rise && !r_done) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              w_done_nxt = 1'b1;
              if (r_state == S_DEV_ADDR) begin
                if (w_byte[7:1] == DEVICE_ADDR) begin
                  w_rw_nxt   = w_byte[0];
                  w_busy_nxt = 1'b1;
                end else begin
                  w_state_nxt = S_IGNORE;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b0;
                end
              end else if (r_state == S_ADDR_H) begin
                w_addr_hi_nxt = w_byte;
              end else if (r_state == S_ADDR_L) begin
                w_ptr_nxt = (ADDR_NUM != 0) ? MEM_AW'({r_addr_hi, w_byte}) : MEM_AW'(w_byte);
              end else begin
                w_wr_en   = 1'b1;
                w_ptr_nxt = w_ptr_inc;
              end
            end
          end else if (w_scl_fall && r_done) begin
            // Byte accepted: pull SDA low for the 9th clock
            w_done_nxt   = 1'b0;
            w_sda_oe_nxt = 1'b1;
            if (r_state == S_DEV_ADDR)    w_state_nxt = S_ACK_DEV;
            else if (r_state == S_ADDR_H) w_state_nxt = S_ACK_AH;
            else if (r_state == S_ADDR_L) w_state_nxt = S_ACK_AL;
            else                          w_state_nxt = S_ACK_WR;
          end
        end
        S_ACK_DEV: begin
          if (w_scl_fall) begin
            w_cnt_nxt = 3'd0;
            if (r_rw) begin
              // First read bit goes out on the same fall that ends the ACK
              w_shift_nxt  = r_mem[r_ptr];
              w_sda_oe_nxt = ~r_mem[r_ptr][7];
              w_state_nxt  = S_RD_DATA;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = (ADDR_NUM != 0) ? S_ADDR_H : S_ADDR_L;
            end
          end
        end
        S_ACK_AH: begin
          if (w_scl_fall) begin
            w_sda_oe_nxt = 1'b0;
            w_cnt_nxt    = 3'd0;
            w_state_nxt  = S_ADDR_L;
          end
        end
        S_ACK_AL, S_ACK_WR: begin
          if (w_scl_fall) begin
            w_sda_oe_nxt = 1'b0;
            w_cnt_nxt    = 3'd0;
            w_state_nxt  = S_WR_DATA;
          end
        end
        S_RD_DATA: begin
          if (w_scl_rise && !r_done) begin
            w_shift_nxt = {r_shift[6:0], 1'b0};
            w_cnt_nxt   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) w_done_nxt = 1'b1;
          end else if (w_scl_fall) begin
            if (r_done) begin
              w_done_nxt   = 1'b0;
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = S_RD_ACK;
            end else begin
              w_sda_oe_nxt = ~r_shift[7];
            end
          end
        end
        S_RD_ACK: begin
          if (w_scl_rise) begin
            w_ptr_nxt = w_ptr_inc;
            if (!r_sda_s2) begin
              // Master ACK: preload next byte, its MSB goes out on the next fall
              w_shift_nxt = r_mem[w_ptr_inc];
              w_cnt_nxt   = 3'd0;
              w_state_nxt = S_RD_DATA;
            end else begin
              w_state_nxt = S_IGNORE;
              w_busy_nxt  = 1'b0;
            end
          end
        end
        S_IDLE, S_IGNORE: begin
          w_sda_oe_nxt = 1'b0;
        end
        default: begin
          w_state_nxt  = S_IDLE;
          w_sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/i2c_eeprom_slave.md
Name: i2c_eeprom_slave

Overview:
I2C target (slave) that answers the team's EEPROM-style master controller: same framing, same device address, 1- or 2-byte word address. It holds a small internal byte memory. It supports byte/page writes, current-address reads and random reads through a repeated START, with sequential read auto-increment. It is used as a bench/loopback responder and as an on-chip register target, and lives on the same sys_clk domain as the master.

Parameters:
DEVICE_ADDR, 7'b1010011, 7-bit address this target acknowledges.
ADDR_NUM, 1, 1 = two word-address bytes (high then low); 0 = one byte.
MEM_AW, 8, memory address width; depth 2^MEM_AW bytes; pointer wraps modulo 2^MEM_AW.

Ports:
sys_clk  input  1  system clock.
sys_rst_n  input  1  asynchronous, active-low reset.
i2c_scl  input  1  bus clock from master.
i2c_sda  inout  1  open-drain data; target only ever drives 0, otherwise 1'bz.
busy  output  1  high from an address-matched START until STOP, NACK or mismatch.
wr_pulse  output  1  one-cycle strobe per byte written to memory.
wr_addr  output  MEM_AW  address of the byte written, valid with wr_pulse.
wr_data  output  8  data written, valid with wr_pulse.

Behaviour:
- Reset is asynchronous and active-low. On reset: SDA released (Z) immediately; busy=0, wr_pulse=0, wr_addr=0, wr_data=0; pointer=0; state=IDLE. Memory contents are not reset.
- SCL and SDA each pass through a 2-FF synchronizer plus one history FF. Derive scl_rise, scl_fall, and:
  - start_det = SDA falls while SCL high.
  - stop_det = SDA rises while SCL high.
- Required margin: SCL high and low phases each ≥ 6 sys_clk. Reference setup is 250 kHz SCL at 50 MHz.
- SDA is sampled on scl_rise. Target SDA changes occur only on scl_fall, registered, so they land ≥ 3 sys_clk after the pin edge.
- stop_det from any state: go to IDLE, release SDA, busy=0.
- start_det from any state (including repeated START): go to DEV_ADDR, clear bit counter, release SDA. The pointer is preserved.
- Bit counter 0..7 counts scl_rise inside byte states. The 8th rise completes the byte (MSB first).
- States:
  - IDLE: wait start_det.
  - DEV_ADDR: shift 8 bits. On the 8th rise, if bits[7:1]==DEVICE_ADDR, latch rw=bit0 and set busy=1; on the next scl_fall pull SDA low and go to ACK_DEV. If there is no match, go to IGNORE with SDA released.
  - ACK_DEV: hold SDA low through the 9th clock; release on the next scl_fall.
    - rw=0: go to ADDR_H if ADDR_NUM=1, else ADDR_L.
    - rw=1: load shift reg with mem[ptr], drive its MSB on that same scl_fall, go to RD_DATA.
  - ADDR_H / ADDR_L: receive byte, then ACK the same way as ACK_DEV.
    - ADDR_H stores the high byte. ADDR_L sets ptr = {hi,lo}[MEM_AW-1:0]; with ADDR_NUM=0, ptr = lo[MEM_AW-1:0].
    - After ACK go to WR_DATA.
  - WR_DATA: receive byte. On the 8th rise write mem[ptr], pulse wr_pulse with wr_addr=ptr and wr_data=byte, then ptr++ (wrap). ACK, then return to WR_DATA for page writes.
  - RD_DATA: on each scl_fall drive SDA low for a 0 bit and release it for a 1 bit. After the 8th bit, release SDA on scl_fall and go to RD_ACK.
  - RD_ACK: sample master SDA on the 9th rise.
    - 0: ptr++ (wrap), load mem[ptr], drive its MSB on the next scl_fall, stay in the RD_DATA loop.
    - 1 (NACK): ptr++, go to IGNORE, busy=0.
  - IGNORE: SDA released; wait for start_det or stop_det.
- A write byte that is cut by START/STOP before its 8th rise is discarded: no wr_pulse, ptr unchanged.
- START/STOP detection has priority over any scl edge in the same cycle.
- Random read = write frame up to ADDR_L, then repeated START with rw=1. Reads use ptr as left by that frame.
- The target never drives SDA high. The master's active-high drive during its own bits is therefore contention-free.

Test Plan:
1. Write, ADDR_NUM=1: START, 0xA6, 0x00, 0x12, 0x5A, STOP → target ACKs all 4 bytes; exactly one wr_pulse with wr_addr=0x12 and wr_data=0x5A; busy falls at STOP.
2. Random read: START, 0xA6, 0x00, 0x12, repeated START, 0xA7 → target ACKs; SDA carries 0x5A MSB-first; master NACK, then STOP → SDA stays Z; ptr=0x13.
3. Sequential read across wrap: preload mem[0xFF]=0x11 and mem[0x00]=0x22; address 0x00FF, read with master ACK then NACK → bytes 0x11 then 0x22.
4. Mismatch: START, 0xA0, 8 more clocks, STOP → SDA never low; busy=0; no wr_pulse.
5. Abort: STOP after 4 bits of a WR_DATA byte → no wr_pulse; state IDLE; next valid write still succeeds at the unchanged address.
6. Reset while the target pulls SDA low (mid-ACK) → SDA is Z and all outputs return to reset values without any clock edge.
